// File: rtl/uart_echo_sched.sv
// Frame buffer controller: rx bytes -> 1Kx8 SDP RAM -> in-order echo to uart_tx. Optional TERM_BYTE close via UART_ECHO_TERM_EN.
// Latency: RAM write 1 clk after i_rx_dv; first o_tx_dv RD_LAT+4 clks after the closing byte's strobe.
// Backpressure: rx bytes arriving during echo are dropped and counted; tx waits on i_tx_active / i_tx_done.
module uart_echo_sched #(
    parameter int          FRAME_LEN = 10,
    parameter int          ADDR_W    = 10,
    parameter int          RD_LAT    = 1,
    parameter logic [7:0]  TERM_BYTE = 8'h0D
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [7:0]        o_mem_wr_data,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [7:0]        i_mem_rd_data,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_frame_len,
    output logic [7:0]        o_drop_cnt
);

`ifdef UART_ECHO_TERM_EN
    localparam bit TERM_EN = 1'b1;
`else
    localparam bit TERM_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = 1;
    localparam logic [ADDR_W:0]   ONE_L     = 1;
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_RWAIT, S_SEND, S_TWAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W:0]   frame_len_q, frame_len_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        drop_q, drop_d;
    logic [1:0]        lat_q, lat_d;
    logic              accept, drop, close;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_len_d = frame_len_q;
        tx_byte_d   = tx_byte_q;
        tx_dv_d     = 1'b0;
        drop_d      = drop_q;
        lat_d       = lat_q;
        accept      = 1'b0;
        drop        = 1'b0;
        // The write issued last cycle decides closure; a byte landing in that same cycle is dropped.
        close = wr_en_q && ((wr_addr_q == LAST_ADDR) || (TERM_EN && (wr_data_q == TERM_BYTE)));

        case (state_q)
            S_IDLE: accept = i_rx_dv;
            S_FILL: begin
                if (close) begin
                    state_d     = S_RD;
                    frame_len_d = {1'b0, wr_addr_q} + ONE_L;
                    drop        = i_rx_dv;
                end else begin
                    accept = i_rx_dv;
                end
            end
            S_RD: begin
                drop    = i_rx_dv;
                lat_d   = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                drop = i_rx_dv;
                if (lat_q == LAT_LAST) begin
                    tx_byte_d = i_mem_rd_data;
                    state_d   = S_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_SEND: begin
                drop = i_rx_dv;
                if (!i_tx_active) begin
                    tx_dv_d = 1'b1;
                    state_d = S_TWAIT;
                end
            end
            S_TWAIT: begin
                drop = i_rx_dv;
                if (i_tx_done) begin
                    if (({1'b0, rd_ptr_q} + ONE_L) == frame_len_q) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ONE_A;
                        state_d  = S_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_data_d = i_rx_byte;
            wr_ptr_d  = wr_ptr_q + ONE_A;
            state_d   = S_FILL;
        end
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_len_q <= '0;
            tx_byte_q   <= '0;
            tx_dv_q     <= 1'b0;
            drop_q      <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_len_q <= frame_len_d;
            tx_byte_q   <= tx_byte_d;
            tx_dv_q     <= tx_dv_d;
            drop_q      <= drop_d;
            lat_q       <= lat_d;
        end
    end

    assign o_mem_wr_en   = wr_en_q;
    assign o_mem_wr_addr = wr_addr_q;
    assign o_mem_wr_data = wr_data_q;
    assign o_mem_rd_en   = (state_q == S_RD);
    assign o_mem_rd_addr = rd_ptr_q;
    assign o_tx_dv       = tx_dv_q;
    assign o_tx_byte     = tx_byte_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_frame_len   = frame_len_q;
    assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_uart_echo_sched.sv
// Directed bench: instance A (FRAME_LEN=10, RD_LAT=1) with an automatic uart_tx responder,
// instance B (FRAME_LEN=1024, RD_LAT=2) with hand-driven tx handshake.
module tb_uart_echo_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A ----------------
    logic       a_rx_dv, a_wr_en, a_rd_en, a_tx_dv, a_tx_active, a_tx_done, a_busy;
    logic [7:0] a_rx_byte, a_wr_data, a_rd_data, a_tx_byte, a_drop;
    logic [9:0] a_wr_addr, a_rd_addr;
    logic [10:0] a_frame_len;
    logic [7:0] a_mem [1024];

    uart_echo_sched u_a (
        .clk(clk), .i_rst_n(rst_n), .i_rx_dv(a_rx_dv), .i_rx_byte(a_rx_byte),
        .o_mem_wr_en(a_wr_en), .o_mem_wr_addr(a_wr_addr), .o_mem_wr_data(a_wr_data),
        .o_mem_rd_en(a_rd_en), .o_mem_rd_addr(a_rd_addr), .i_mem_rd_data(a_rd_data),
        .o_tx_dv(a_tx_dv), .o_tx_byte(a_tx_byte), .i_tx_active(a_tx_active), .i_tx_done(a_tx_done),
        .o_busy(a_busy), .o_frame_len(a_frame_len), .o_drop_cnt(a_drop)
    );

    always @(posedge clk) begin
        if (a_wr_en) a_mem[a_wr_addr] <= a_wr_data;
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    end

    // ---------------- instance B ----------------
    logic       b_rx_dv, b_wr_en, b_rd_en, b_tx_dv, b_tx_active, b_tx_done, b_busy;
    logic [7:0] b_rx_byte, b_wr_data, b_rd_p1, b_rd_data, b_tx_byte, b_drop;
    logic [9:0] b_wr_addr, b_rd_addr;
    logic [10:0] b_frame_len;
    logic [7:0] b_mem [1024];

    uart_echo_sched #(.FRAME_LEN(1024), .ADDR_W(10), .RD_LAT(2)) u_b (
        .clk(clk), .i_rst_n(rst_n), .i_rx_dv(b_rx_dv), .i_rx_byte(b_rx_byte),
        .o_mem_wr_en(b_wr_en), .o_mem_wr_addr(b_wr_addr), .o_mem_wr_data(b_wr_data),
        .o_mem_rd_en(b_rd_en), .o_mem_rd_addr(b_rd_addr), .i_mem_rd_data(b_rd_data),
        .o_tx_dv(b_tx_dv), .o_tx_byte(b_tx_byte), .i_tx_active(b_tx_active), .i_tx_done(b_tx_done),
        .o_busy(b_busy), .o_frame_len(b_frame_len), .o_drop_cnt(b_drop)
    );

    always @(posedge clk) begin
        if (b_wr_en) b_mem[b_wr_addr] <= b_wr_data;
        if (b_rd_en) b_rd_p1 <= b_mem[b_rd_addr];
        b_rd_data <= b_rd_p1;
    end

    // ---------------- A-side uart_tx responder and write monitor ----------------
    int         a_tx_cyc   = 6;
    int         a_done_cnt = 0;
    logic [7:0] a_echo_q[$];
    int         a_dv_cyc_q[$];
    logic [9:0] a_wr_addr_q[$];
    int         a_wr_cnt = 0;

    initial begin
        a_tx_active = 1'b0;
        a_tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (a_tx_dv) begin
                a_echo_q.push_back(a_tx_byte);
                a_dv_cyc_q.push_back(cyc);
                a_tx_active = 1'b1;
                repeat (a_tx_cyc) @(negedge clk);
                a_tx_active = 1'b0;
                a_tx_done   = 1'b1;
                a_done_cnt++;
                @(negedge clk);
                a_tx_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (a_wr_en) begin
            a_wr_cnt++;
            a_wr_addr_q.push_back(a_wr_addr);
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_send(input logic [7:0] b, input int gap);
        exp_q.push_back(b);
        a_rx_dv   = 1'b1;
        a_rx_byte = b;
        step();
        a_rx_dv = 1'b0;
        step(gap);
    endtask

    task automatic a_wait_idle(input string tag);
        int n = 0;
        while (a_busy && n < 2000) begin
            step();
            n++;
        end
        check(tag, a_busy, 1'b0);
    endtask

    task automatic a_check_echo(input string tag, input int base);
        check({tag, "_cnt"}, a_echo_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < a_echo_q.size()) check(tag, a_echo_q[base + i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    function automatic logic [7:0] b_pat(input int k);
        logic [7:0] v;
        v = 8'(k) ^ 8'h5A;
        return (v == 8'h0D) ? 8'h0E : v;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int base, wbase, wcnt, n, good;
        rst_n = 1'b1;
        a_rx_dv = 1'b0; a_rx_byte = 8'h00;
        b_rx_dv = 1'b0; b_rx_byte = 8'h00; b_tx_active = 1'b0; b_tx_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_flags", {a_wr_en, a_rd_en, a_tx_dv, a_busy}, 4'b0000);
        check("rst_frame_len", a_frame_len, 11'd0);
        check("rst_drop", a_drop, 8'd0);
        check("rst_tx_byte", a_tx_byte, 8'd0);
        check("rst_addrs", {a_wr_addr, a_rd_addr}, 20'd0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // Frame 0x30..0x39, one byte per ~12 clocks
        base = a_echo_q.size(); wbase = a_wr_addr_q.size();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'h30 + 8'(i));
            a_rx_dv = 1'b1; a_rx_byte = 8'h30 + 8'(i);
            step();
            a_rx_dv = 1'b0;
            check("wr_en_n1", a_wr_en, 1'b1);
            check("wr_addr", a_wr_addr, 10'(i));
            check("wr_data", a_wr_data, 8'h30 + 8'(i));
            if (i < 9) begin
                step();
                check("wr_en_width", a_wr_en, 1'b0);
                step(10);
            end
        end
        step();                         // N+2
        check("close_rd_en", a_rd_en, 1'b1);
        check("close_rd_addr", a_rd_addr, 10'd0);
        check("close_frame_len", a_frame_len, 11'd10);
        step();                         // N+3
        check("rd_en_width", a_rd_en, 1'b0);
        step();                         // N+4
        check("capture_byte", a_tx_byte, 8'h30);
        check("dv_not_early", a_tx_dv, 1'b0);
        step();                         // N+5
        check("dv_at_n5", a_tx_dv, 1'b1);
        step();
        check("dv_width", a_tx_dv, 1'b0);
        a_wait_idle("t1_busy_fall");
        check("t1_done_cnt", a_done_cnt, 10);
        a_check_echo("t1_echo", base);
        check("t1_wr_cnt", a_wr_addr_q.size() - wbase, 10);
        for (int i = 0; i < 10; i++) check("t1_wr_addr_seq", a_wr_addr_q[wbase + i], 10'(i));
        check("t1_dv_gap", a_dv_cyc_q[base + 1] - a_dv_cyc_q[base], a_tx_cyc + 4);

        // Terminator byte handling
        base = a_echo_q.size();
        a_send(8'h41, 3);
        a_send(8'h42, 3);
        a_send(8'h0D, 3);
        step(5);
`ifdef UART_ECHO_TERM_EN
        a_wait_idle("term_busy_fall");
        check("term_frame_len", a_frame_len, 11'd3);
        a_check_echo("term_echo", base);
`else
        check("noterm_busy", a_busy, 1'b1);
        check("noterm_rd_en", a_rd_en, 1'b0);
        exp_q.push_back(8'h43);
        a_rx_dv = 1'b1; a_rx_byte = 8'h43;
        step();
        a_rx_dv = 1'b0;
        check("noterm_wr_ptr3", a_wr_addr, 10'd3);
        step(2);
        for (int i = 0; i < 6; i++) a_send(8'h44 + 8'(i), 2);
        a_wait_idle("noterm_busy_fall");
        check("noterm_frame_len", a_frame_len, 11'd10);
        a_check_echo("noterm_echo", base);
`endif

        // Three bytes dropped during echo
        base = a_echo_q.size();
        for (int i = 0; i < 10; i++) a_send(8'h70 + 8'(i), (i < 9) ? 3 : 1);
        wcnt = a_wr_cnt;
        for (int i = 0; i < 3; i++) begin
            a_rx_dv = 1'b1; a_rx_byte = 8'hEE;
            step();
            a_rx_dv = 1'b0;
            step(5);
        end
        a_wait_idle("drop3_busy_fall");
        check("drop3_cnt", a_drop, 8'd3);
        check("drop3_no_write", a_wr_cnt, wcnt);
        check("drop3_frame_len", a_frame_len, 11'd10);
        a_check_echo("drop3_echo", base);

        // 300 drops saturate
        a_tx_cyc = 40;
        base = a_echo_q.size();
        for (int i = 0; i < 10; i++) a_send(8'h80 + 8'(i), (i < 9) ? 2 : 1);
        a_rx_dv = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a_rx_byte = 8'(i);
            step();
        end
        a_rx_dv = 1'b0;
        check("sat_still_echoing", a_busy, 1'b1);
        check("sat_drop_cnt", a_drop, 8'd255);
        a_wait_idle("sat_busy_fall");
        a_check_echo("sat_echo", base);
        a_tx_cyc = 6;

        // Reset after 5th echoed byte
        base = a_echo_q.size();
        for (int i = 0; i < 10; i++) a_send(8'h50 + 8'(i), 2);
        n = 0;
        while ((a_echo_q.size() - base) < 5 && n < 1000) begin
            step();
            n++;
        end
        check("rst5_reached", a_echo_q.size() - base, 5);
        rst_n = 1'b0;
        #1;
        check("arst_flags", {a_wr_en, a_rd_en, a_tx_dv, a_busy}, 4'b0000);
        check("arst_wr", {a_wr_addr, a_wr_data}, 18'd0);
        check("arst_rd_addr", a_rd_addr, 10'd0);
        check("arst_tx_byte", a_tx_byte, 8'd0);
        check("arst_frame_len", a_frame_len, 11'd0);
        check("arst_drop", a_drop, 8'd0);
        step(2);
        rst_n = 1'b1;
        step(a_tx_cyc + 4);
        check("late_done_ignored", a_busy, 1'b0);
        exp_q.delete();
        base = a_echo_q.size(); wbase = a_wr_addr_q.size();
        for (int i = 0; i < 10; i++) a_send(8'h60 + 8'(i), 2);
        check("post_rst_wr_addr0", a_wr_addr_q[wbase], 10'd0);
        a_wait_idle("post_rst_busy_fall");
        a_check_echo("post_rst_echo", base);

        // Instance B: 1024-byte frame, RD_LAT=2, tx busy held after capture
        b_tx_active = 1'b1;
        b_rx_dv = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            b_rx_byte = b_pat(k);
            step();
        end
        b_rx_dv = 1'b0;
        check("big_last_wr_en", b_wr_en, 1'b1);
        check("big_last_wr_addr", b_wr_addr, 10'd1023);
        check("big_last_wr_data", b_wr_data, 8'hA5);
        step();
        check("big_frame_len", b_frame_len, 11'd1024);
        check("big_rd_en", {b_rd_en, b_rd_addr}, {1'b1, 10'd0});
        step(3);
        check("big_capture", b_tx_byte, 8'h5A);
        step(20);
        check("big_hold_no_dv", b_tx_dv, 1'b0);
        check("big_hold_byte", b_tx_byte, 8'h5A);
        b_tx_active = 1'b0;
        step();
        check("big_dv_after_active", b_tx_dv, 1'b1);
        step();
        check("big_dv_width", b_tx_dv, 1'b0);
        step();
        b_tx_done = 1'b1; b_rx_dv = 1'b1; b_rx_byte = 8'h99;
        step();
        b_tx_done = 1'b0; b_rx_dv = 1'b0;
        check("same_cycle_drop", b_drop, 8'd1);
        check("same_cycle_rd", {b_rd_en, b_rd_addr}, {1'b1, 10'd1});
        n = 1;
        while (!b_tx_dv && n < 20) begin
            step();
            n++;
        end
        check("big_done_to_dv_gap", n, 5);
        good = 0;
        for (int k = 1; k < 1024; k++) begin
            if (b_tx_byte == b_pat(k)) good++;
            if (k == 1023) check("big_last_echo", b_tx_byte, 8'hA5);
            step(2);
            b_tx_done = 1'b1;
            step();
            b_tx_done = 1'b0;
            if (k < 1023) begin
                n = 0;
                while (!b_tx_dv && n < 20) begin
                    step();
                    n++;
                end
                if (!b_tx_dv) begin
                    check("big_dv_wait", b_tx_dv, 1'b1);
                    break;
                end
            end
        end
        check("big_echo_bytes", good, 1023);
        check("big_idle", b_busy, 1'b0);
        check("big_rd_ptr0", b_rd_addr, 10'd0);
        b_tx_done = 1'b1;
        step();
        b_tx_done = 1'b0;
        step();
        check("spurious_done", b_busy, 1'b0);
        b_rx_dv = 1'b1; b_rx_byte = 8'h11;
        step();
        b_rx_dv = 1'b0;
        check("big_wr_ptr0", b_wr_addr, 10'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/uart_echo_sched.md
# uart_echo_sched

Frame-level controller for the UART receive/echo datapath. It takes bytes from `uart_rx`, writes them into the 1K×8 simple-dual-port block RAM, and closes a frame on a length limit. It then reads the frame back in order and feeds it byte by byte to `uart_tx` through that module's DV/Done handshake. It sits between `uart_rx`, `blk_mem_1b_1k` and `uart_tx`, and owns every enable, address and DV strobe on that path.

## Interface
- `FRAME_LEN`, 10: bytes per frame; legal range 1..1024.
- `ADDR_W`, 10: RAM address width.
- `RD_LAT`, 1: RAM read latency in clocks, from `o_mem_rd_en` to valid `i_mem_rd_data`; legal values 1 or 2.
- `TERM_BYTE`, 8'h0D: frame terminator; used only when `UART_ECHO_TERM_EN` is defined.
- `clk` in 1: single clock for all logic.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_rx_dv` in 1: one-cycle strobe from `uart_rx`.
- `i_rx_byte` in 8: received byte; valid while `i_rx_dv` is high.
- `o_mem_wr_en` out 1: drives both port-A `ena` and `wea`.
- `o_mem_wr_addr` out ADDR_W: port-A address.
- `o_mem_wr_data` out 8: port-A data.
- `o_mem_rd_en` out 1: port-B `enb`.
- `o_mem_rd_addr` out ADDR_W: port-B address.
- `i_mem_rd_data` in 8: port-B `doutb`.
- `o_tx_dv` out 1: one-cycle start strobe to `uart_tx`.
- `o_tx_byte` out 8: byte to transmit; held stable until `i_tx_done`.
- `i_tx_active` in 1: `uart_tx` busy flag.
- `i_tx_done` in 1: `uart_tx` completion pulse.
- `o_busy` out 1: high in any state other than IDLE.
- `o_frame_len` out ADDR_W+1: length of the last closed frame.
- `o_drop_cnt` out 8: saturating count of bytes dropped while in a TX state.

## Operation
- Reset values: all outputs 0; state IDLE; write pointer and read pointer 0.
- State IDLE: on `i_rx_dv`, go to FILL and perform that byte's write.
- State FILL, write path:
  - Each `i_rx_dv` registers a write on the next cycle: `o_mem_wr_en`=1 for exactly one clock, `o_mem_wr_addr`=write pointer, `o_mem_wr_data`=`i_rx_byte`.
  - The write pointer then increments.
- Frame close: when the byte just written brings the count to FRAME_LEN, latch `o_frame_len` and go to RD.
- State RD: assert `o_mem_rd_en` for one clock with `o_mem_rd_addr`=read pointer, then go to RWAIT.
- State RWAIT: after RD_LAT clocks, capture `i_mem_rd_data` into `o_tx_byte` and go to SEND.
- State SEND: when `i_tx_active`=0, pulse `o_tx_dv` for one clock and go to TWAIT. While `i_tx_active`=1, stay in SEND.
- State TWAIT: on `i_tx_done`:
  - If read pointer = `o_frame_len`−1: clear both pointers and go to IDLE.
  - Otherwise: increment the read pointer and go to RD.
- Bytes received during RD, RWAIT, SEND or TWAIT are not written. Each one increments `o_drop_cnt`, which saturates at 255.
- Arithmetic: pointers are ADDR_W bits. `o_frame_len` is ADDR_W+1 bits so that 1024 is representable. A frame never wraps the RAM.
- Reset asserted mid-frame or mid-transmit: the block returns to the reset state immediately.
  - An in-flight `uart_tx` byte completes on its own.
  - Its `i_tx_done` arrives in IDLE and is ignored.
- `i_tx_done` outside TWAIT and `i_rx_dv` in IDLE with no pending state are handled only as described above. A spurious `i_tx_done` is ignored.

## Timing
- Write latency: `i_rx_dv` at cycle N gives `o_mem_wr_en` at N+1.
- Frame close: the state is RD at N+2 after the final byte's strobe.
- RX-to-TX latency for the first byte, with TX idle and RD_LAT=1: `o_tx_dv` at N+5 after the final `i_rx_dv`. The sequence is RD N+2, RWAIT N+3, capture N+4, SEND N+4, DV N+5.
- Per byte, the gap from `i_tx_done` to the next `o_tx_dv` is RD_LAT+3 clocks.
- The `o_mem_rd_en` and `o_tx_dv` pulses are exactly one clock wide. `o_tx_byte` changes only on capture.
- If `i_rx_dv` and `i_tx_done` occur in the same cycle, both are processed independently: the drop count increments and the TWAIT transition happens.

## Configuration
- `UART_ECHO_TERM_EN` defined: FILL also closes the frame when the written byte equals TERM_BYTE. The terminator is stored and echoed. Length and terminator closure coincide harmlessly.
- `UART_ECHO_TERM_EN` undefined: frames close only at FRAME_LEN, and TERM_BYTE is unused.

## Test plan
- Reset, then 10 bytes 0x30..0x39 spaced one UART frame apart:
  - Writes go to addresses 0..9.
  - `o_frame_len`=10.
  - `uart_tx` emits 0x30..0x39 in order.
  - `o_busy` falls after the 10th `i_tx_done`.
- With `UART_ECHO_TERM_EN` defined, send 0x41 0x42 0x0D: `o_frame_len`=3 and the echo is 0x41 0x42 0x0D. Without the macro, the block stays in FILL with a write pointer of 3.
- During echo of a 10-byte frame, inject 3 rx bytes: `o_drop_cnt`=3, the RAM is unchanged, and the echo output is unchanged. Inject 300 bytes: `o_drop_cnt`=255.
- Assert `i_rst_n`=0 after the 5th echoed byte's `o_tx_dv`: all outputs return to 0 asynchronously. A new 10-byte frame then echoes correctly starting from address 0.
- With RD_LAT=2 and `i_tx_active` held high for 20 clocks after capture: `o_tx_dv` fires on the first cycle after `i_tx_active` falls, and `o_tx_byte` matches RAM[0].
- With FRAME_LEN=1024, 1024 bytes: the last write goes to address 1023, `o_frame_len`=1024, the final echo byte is correct, and the pointers return to 0.
